// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result FIFOs drained round-robin onto CDB_COUNT broadcast ports.
// Optional same-cycle bypass of empty FIFOs is enabled by defining CDB_ARB_BYPASS_EN.
package cdb_pkg;
  typedef logic [31:0] word_t;
  typedef logic [5:0]  rob_id_t;
  typedef struct packed {
    rob_id_t rob_id;
    word_t   w_data;
  } cdb_info_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int EU_COUNT   = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int CDB_COUNT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  cdb_info_t            eu_result_i  [EU_COUNT],
  input  logic [EU_COUNT-1:0]  eu_valid_i,
  output logic [EU_COUNT-1:0]  eu_ready_o,
  output cdb_info_t            cdb_o        [CDB_COUNT],
  output word_t                cdb_data_o   [CDB_COUNT],
  output rob_id_t              cdb_reg_id_o [CDB_COUNT],
  output logic [CDB_COUNT-1:0] cdb_valid_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (EU_COUNT > 1) ? $clog2(EU_COUNT) : 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  cdb_info_t     mem_q   [EU_COUNT][FIFO_DEPTH];
  logic [PW-1:0] head_q  [EU_COUNT];
  logic [PW-1:0] tail_q  [EU_COUNT];
  logic [CW-1:0] count_q [EU_COUNT];
  logic [RW-1:0] rr_q, rr_d;

  logic                active;
  logic [EU_COUNT-1:0] empty, push, cand, grant, wr_en, rd_en;
  cdb_info_t           cand_data [EU_COUNT];

  // Ready comes from the registered count only, so a full FIFO stays
  // not-ready even in a cycle where it is being popped.
  assign active = !rst && !flush;

  always_comb begin
    for (int i = 0; i < EU_COUNT; i++) begin
      empty[i]      = (count_q[i] == '0);
      eu_ready_o[i] = active && (count_q[i] < FULL);
      push[i]       = eu_valid_i[i] && eu_ready_o[i];
`ifdef CDB_ARB_BYPASS_EN
      cand[i]      = !empty[i] || push[i];
      cand_data[i] = empty[i] ? eu_result_i[i] : mem_q[i][head_q[i]];
`else
      cand[i]      = !empty[i];
      cand_data[i] = mem_q[i][head_q[i]];
`endif
    end
  end

  // Scan producers starting at rr_q; the n-th winner in scan order drives port n.
  always_comb begin
    int n;
    n           = 0;
    grant       = '0;
    cdb_valid_o = '0;
    rr_d        = rr_q;
    for (int k = 0; k < CDB_COUNT; k++) cdb_o[k] = '0;
    if (active) begin
      for (int j = 0; j < EU_COUNT; j++) begin
        for (int i = 0; i < EU_COUNT; i++) begin
          if (((int'(rr_q) + j) % EU_COUNT) == i && cand[i] && n < CDB_COUNT) begin
            grant[i] = 1'b1;
            for (int k = 0; k < CDB_COUNT; k++) begin
              if (k == n) begin
                cdb_o[k]       = cand_data[i];
                cdb_valid_o[k] = 1'b1;
              end
            end
            rr_d = RW'((i + 1) % EU_COUNT);
            n    = n + 1;
          end
        end
      end
    end
    for (int k = 0; k < CDB_COUNT; k++) begin
      cdb_data_o[k]   = cdb_o[k].w_data;
      cdb_reg_id_o[k] = cdb_o[k].rob_id;
    end
  end

  // A grant on an empty FIFO can only be a bypass: that result is consumed
  // directly and never written.
  always_comb begin
    for (int i = 0; i < EU_COUNT; i++) begin
      wr_en[i] = push[i] && !(grant[i] && empty[i]);
      rd_en[i] = grant[i] && !empty[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_q <= '0;
      for (int i = 0; i < EU_COUNT; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < EU_COUNT; i++) begin
        if (wr_en[i]) tail_q[i] <= tail_q[i] + 1'b1;
        if (rd_en[i]) head_q[i] <= head_q[i] + 1'b1;
        count_q[i] <= count_q[i] + {{(CW-1){1'b0}}, wr_en[i]} - {{(CW-1){1'b0}}, rd_en[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < EU_COUNT; i++) begin
      if (wr_en[i]) mem_q[i][tail_q[i]] <= eu_result_i[i];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 4x2 instance for the main scenarios and a
// 4x1 instance for backpressure and full-with-pop behaviour.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  cdb_info_t  res  [4];
  logic [3:0] vld, rdy;
  cdb_info_t  cdb  [2];
  word_t      cdata[2];
  rob_id_t    cid  [2];
  logic [1:0] cval;

  cdb_info_t  res1  [4];
  logic [3:0] vld1, rdy1;
  cdb_info_t  cdb1  [1];
  word_t      cdata1[1];
  rob_id_t    cid1  [1];
  logic [0:0] cval1;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.EU_COUNT(4), .FIFO_DEPTH(2), .CDB_COUNT(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .eu_result_i(res), .eu_valid_i(vld), .eu_ready_o(rdy),
    .cdb_o(cdb), .cdb_data_o(cdata), .cdb_reg_id_o(cid), .cdb_valid_o(cval)
  );

  cdb_arbiter #(.EU_COUNT(4), .FIFO_DEPTH(2), .CDB_COUNT(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .eu_result_i(res1), .eu_valid_i(vld1), .eu_ready_o(rdy1),
    .cdb_o(cdb1), .cdb_data_o(cdata1), .cdb_reg_id_o(cid1), .cdb_valid_o(cval1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input int id);
    res[i].rob_id = rob_id_t'(id);
    res[i].w_data = word_t'(32'h1000 + id);
    vld[i]        = 1'b1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    vld   = '0;
    vld1  = '0;
    for (int i = 0; i < 4; i++) begin
      res[i]  = '0;
      res1[i] = '0;
    end
    res1[0].rob_id = 6'd1;
    res1[1].rob_id = 6'd2;

    // reset
    tick; tick; #3;
    check("rst_ready", rdy, 4'h0);
    check("rst_valid", cval, 2'b00);
    check("rst_payload0", cdb[0], '0);
    check("rst_reg1", cid[1], 0);
    check("rst_ready1", rdy1, 4'h0);
    tick; rst = 1'b0; #3;
    check("post_rst_ready", rdy, 4'hf);
    check("post_rst_valid", cval, 2'b00);

    // single push: visible one cycle later, then gone
    tick; put(0, 5); #3;
    check("single_c0_valid", cval, 2'b00);
    tick; vld = '0; #3;
    check("single_c1_valid", cval, 2'b01);
    check("single_c1_reg", cid[0], 5);
    check("single_c1_data", cdata[0], 32'h1005);
    tick; #3;
    check("single_c2_valid", cval, 2'b00);

    // rr_q is now 1: EU1 wins port 0 over EU0
    tick; put(0, 6); put(1, 7); #3;
    tick; vld = '0; #3;
    check("rr1_valid", cval, 2'b11);
    check("rr1_port0", cid[0], 7);
    check("rr1_port1", cid[1], 6);

    // flush with three buffered results, plus a push in the flush cycle
    tick; put(0, 10); put(1, 11); put(2, 12); #3;
    tick; vld = '0; flush = 1'b1; put(3, 13); #3;
    check("flush_valid", cval, 2'b00);
    check("flush_ready", rdy, 4'h0);
    tick; flush = 1'b0; vld = '0; #3;
    check("post_flush_valid", cval, 2'b00);
    check("post_flush_ready", rdy, 4'hf);
    tick; #3;
    check("post_flush_quiet", cval, 2'b00);

    // four-way contention from rr_q=0
    tick; put(0, 20); put(1, 21); put(2, 22); put(3, 23); #3;
    tick; vld = '0; #3;
    check("four_a_valid", cval, 2'b11);
    check("four_a_port0", cid[0], 20);
    check("four_a_port1", cid[1], 21);
    tick; #3;
    check("four_b_valid", cval, 2'b11);
    check("four_b_port0", cid[0], 22);
    check("four_b_port1", cid[1], 23);
    tick; #3;
    check("four_idle", cval, 2'b00);
    tick; put(0, 24); put(3, 25); #3;
    tick; vld = '0; #3;
    check("rr0_port0", cid[0], 24);
    check("rr0_port1", cid[1], 25);

    // simultaneous push and pop on EU1 keeps order
    tick; put(1, 30); #3;
    tick; put(1, 31); #3;
    check("pp_first_valid", cval, 2'b01);
    check("pp_first_reg", cid[0], 30);
    check("pp_ready", rdy[1], 1'b1);
    tick; vld = '0; #3;
    check("pp_second_valid", cval, 2'b01);
    check("pp_second_reg", cid[0], 31);
    tick; #3;
    check("pp_idle", cval, 2'b00);

    // reset mid-burst discards buffered results
    tick; put(0, 40); put(1, 41); put(2, 42); put(3, 43); #3;
    tick; vld = '0; rst = 1'b1; #3;
    check("mid_rst_valid", cval, 2'b00);
    check("mid_rst_ready", rdy, 4'h0);
    check("mid_rst_payload0", cdb[0], '0);
    check("mid_rst_reg1", cid[1], 0);
    tick; rst = 1'b0; #3;
    check("after_rst_valid", cval, 2'b00);
    check("after_rst_ready", rdy, 4'hf);
    tick; put(2, 45); put(1, 46); #3;
    tick; vld = '0; #3;
    check("after_rst_port0", cid[0], 46);
    check("after_rst_port1", cid[1], 45);

    // backpressure on the single-port instance: EU0/EU1 always pushing
    tick; #3;
    for (int c = 0; c < 10; c++) begin
      tick;
      vld1 = {1'b0, (c <= 4), 2'b11};
      res1[2].rob_id = (c == 0) ? 6'd50 : (c == 1) ? 6'd51 : 6'd52;
      #3;
      case (c)
        0: begin check("bp_c0_ready2", rdy1[2], 1'b1); check("bp_c0_valid", cval1, 1'b0); end
        1: begin check("bp_c1_ready2", rdy1[2], 1'b1); check("bp_c1_reg", cid1[0], 1); end
        2: begin check("bp_c2_ready2", rdy1[2], 1'b0); check("bp_c2_reg", cid1[0], 2); end
        3: begin check("bp_c3_ready2", rdy1[2], 1'b0); check("bp_c3_reg", cid1[0], 50); end
        4: begin check("bp_c4_ready2", rdy1[2], 1'b1); check("bp_c4_reg", cid1[0], 1); end
        5: check("bp_c5_reg", cid1[0], 2);
        6: check("bp_c6_reg", cid1[0], 51);
        7: check("bp_c7_reg", cid1[0], 1);
        8: check("bp_c8_reg", cid1[0], 2);
        default: check("bp_c9_reg", cid1[0], 52);
      endcase
    end
    tick; vld1 = '0; #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
